// File: rtl/sm83_ir_seq.sv
// sm83_ir_seq: instruction-register sequencer for the SM83 core.
// Fetches opcode bytes, tracks the CB-prefix bank, injects interrupt
// entry as a pseudo-instruction and implements HALT wait.
// Optional feature macro: SM83_HALT_BUG_EN (HALT with IME=0 and an
// interrupt pending makes the following fetch skip its PC increment).
module sm83_ir_seq #(
    parameter logic [7:0] RESET_OPCODE  = 8'h00,
    parameter logic [7:0] HALT_OPCODE   = 8'h76,
    parameter logic [7:0] PREFIX_OPCODE = 8'hCB
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fetch_data,
    input  logic       fetch_valid,
    output logic       fetch_req,
    output logic       pc_inc,
    input  logic       instr_done,
    input  logic       irq_pending,
    input  logic       ime,
    output logic       irq_ack,
    output logic [7:0] opcode,
    output logic       bank_cb,
    output logic       intr_entry,
    output logic       ir_valid,
    output logic       halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic       bank_cb_q, bank_cb_d;
    logic       intr_entry_q, intr_entry_d;
    logic       pc_inc_q, pc_inc_d;
    logic       irq_ack_q, irq_ack_d;
`ifdef SM83_HALT_BUG_EN
    logic       halt_bug_q, halt_bug_d;
`endif

    // State and instruction-register flops; reset discards any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            opcode_q     <= RESET_OPCODE;
            bank_cb_q    <= 1'b0;
            intr_entry_q <= 1'b0;
            pc_inc_q     <= 1'b0;
            irq_ack_q    <= 1'b0;
`ifdef SM83_HALT_BUG_EN
            halt_bug_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            bank_cb_q    <= bank_cb_d;
            intr_entry_q <= intr_entry_d;
            pc_inc_q     <= pc_inc_d;
            irq_ack_q    <= irq_ack_d;
`ifdef SM83_HALT_BUG_EN
            halt_bug_q   <= halt_bug_d;
`endif
        end
    end

    // Next-state and instruction-register updates, including the prioritised end-of-instruction rules.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        bank_cb_d    = bank_cb_q;
        intr_entry_d = intr_entry_q;
        pc_inc_d     = 1'b0;
        irq_ack_d    = 1'b0;
`ifdef SM83_HALT_BUG_EN
        halt_bug_d   = halt_bug_q;
`endif
        case (state_q)
            ST_FETCH: begin
                // bank_cb is held so the byte after a prefix decodes in the CB bank
                if (fetch_valid) begin
                    opcode_d = fetch_data;
                    state_d  = ST_EXEC;
`ifdef SM83_HALT_BUG_EN
                    if (halt_bug_q) begin
                        halt_bug_d = 1'b0;
                    end else begin
                        pc_inc_d = 1'b1;
                    end
`else
                    pc_inc_d = 1'b1;
`endif
                end
            end
            ST_EXEC: begin
                if (instr_done) begin
                    if (!bank_cb_q && !intr_entry_q && opcode_q == PREFIX_OPCODE) begin
                        // no interrupt may split the prefix from its CB opcode
                        bank_cb_d = 1'b1;
                        state_d   = ST_FETCH;
                    end else if (irq_pending && ime && !intr_entry_q) begin
                        intr_entry_d = 1'b1;
                        opcode_d     = RESET_OPCODE;
                        bank_cb_d    = 1'b0;
                        irq_ack_d    = 1'b1;
                    end else if (!bank_cb_q && !intr_entry_q && opcode_q == HALT_OPCODE) begin
                        bank_cb_d = 1'b0;
                        if (irq_pending) begin
                            // IME is necessarily 0 here: HALT falls straight through
                            state_d = ST_FETCH;
`ifdef SM83_HALT_BUG_EN
                            halt_bug_d = 1'b1;
`endif
                        end else begin
                            state_d = ST_HALTED;
                        end
                    end else begin
                        bank_cb_d    = 1'b0;
                        intr_entry_d = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                if (irq_pending) begin
                    if (ime) begin
                        state_d      = ST_EXEC;
                        intr_entry_d = 1'b1;
                        opcode_d     = RESET_OPCODE;
                        bank_cb_d    = 1'b0;
                        irq_ack_d    = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State-decoded handshake and status outputs; fetch_req is masked while reset is held.
    always_comb begin
        fetch_req = (state_q == ST_FETCH) && !reset;
        ir_valid  = (state_q == ST_EXEC);
        halted    = (state_q == ST_HALTED);
    end

    assign opcode     = opcode_q;
    assign bank_cb    = bank_cb_q;
    assign intr_entry = intr_entry_q;
    assign pc_inc     = pc_inc_q;
    assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_sm83_ir_seq.sv
// Testbench for sm83_ir_seq: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_sm83_ir_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fetch_data;
    logic       fetch_valid;
    logic       fetch_req;
    logic       pc_inc;
    logic       instr_done;
    logic       irq_pending;
    logic       ime;
    logic       irq_ack;
    logic [7:0] opcode;
    logic       bank_cb;
    logic       intr_entry;
    logic       ir_valid;
    logic       halted;

    sm83_ir_seq dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .fetch_req  (fetch_req),
        .pc_inc     (pc_inc),
        .instr_done (instr_done),
        .irq_pending(irq_pending),
        .ime        (ime),
        .irq_ack    (irq_ack),
        .opcode     (opcode),
        .bank_cb    (bank_cb),
        .intr_entry (intr_entry),
        .ir_valid   (ir_valid),
        .halted     (halted)
    );

    always #5 clk = ~clk;

`ifdef SM83_HALT_BUG_EN
    localparam bit HB_EN = 1'b1;
`else
    localparam bit HB_EN = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // flag order: bank_cb, intr_entry, ir_valid, halted, fetch_req, pc_inc, irq_ack
    typedef struct {
        logic       rst;
        logic [7:0] fd;
        logic       fv;
        logic       done;
        logic       irq;
        logic       ie;
        logic [7:0] e_op;
        logic [6:0] e_fl;
    } vec_t;

    vec_t tbl[23];

    // behavioural model: what the sequencer is doing, in plain terms
    localparam int WAITING_BYTE = 0;
    localparam int RUNNING      = 1;
    localparam int SLEEPING     = 2;
    int         m_mode;
    logic [7:0] m_op;
    logic       m_cb, m_ie, m_skip_inc, m_pci, m_ack;

    function automatic logic [6:0] dut_flags();
        return {bank_cb, intr_entry, ir_valid, halted, fetch_req, pc_inc, irq_ack};
    endfunction

    function automatic logic [6:0] model_flags();
        return {m_cb, m_ie, (m_mode == RUNNING), (m_mode == SLEEPING),
                (m_mode == WAITING_BYTE) && !reset, m_pci, m_ack};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_update();
        if (reset) begin
            m_mode = WAITING_BYTE; m_op = 8'h00; m_cb = 0; m_ie = 0;
            m_skip_inc = 0; m_pci = 0; m_ack = 0;
        end else begin
            m_pci = 0;
            m_ack = 0;
            if (m_mode == WAITING_BYTE) begin
                if (fetch_valid) begin
                    m_op = fetch_data;
                    m_mode = RUNNING;
                    if (m_skip_inc) m_skip_inc = 0;
                    else m_pci = 1;
                end
            end else if (m_mode == RUNNING) begin
                if (instr_done) begin
                    if (!m_cb && !m_ie && m_op == 8'hCB) begin
                        m_cb = 1; m_mode = WAITING_BYTE;
                    end else if (irq_pending && ime && !m_ie) begin
                        m_ie = 1; m_op = 8'h00; m_cb = 0; m_ack = 1;
                    end else if (!m_cb && !m_ie && m_op == 8'h76) begin
                        if (irq_pending) begin
                            m_mode = WAITING_BYTE;
                            m_skip_inc = HB_EN;
                        end else begin
                            m_mode = SLEEPING;
                        end
                    end else begin
                        m_cb = 0; m_ie = 0; m_mode = WAITING_BYTE;
                    end
                end
            end else begin
                if (irq_pending && ime) begin
                    m_mode = RUNNING; m_ie = 1; m_op = 8'h00; m_cb = 0; m_ack = 1;
                end else if (irq_pending) begin
                    m_mode = WAITING_BYTE;
                end
            end
        end
    endtask

    // apply inputs at a falling edge, clock once, return at the next falling edge
    task automatic step(input logic r, input logic [7:0] d, input logic fv,
                        input logic dn, input logic iq, input logic ie_in);
        reset = r; fetch_data = d; fetch_valid = fv;
        instr_done = dn; irq_pending = iq; ime = ie_in;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000};
        tbl[1]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000000};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000100};
        tbl[3]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 7'b0010010};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 7'b0010000};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 7'b0000100};
        tbl[6]  = '{1'b0, 8'hCB, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCB, 7'b0010010};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hCB, 7'b1000100};
        tbl[8]  = '{1'b0, 8'h37, 1'b1, 1'b0, 1'b1, 1'b1, 8'h37, 7'b1010010};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 7'b0110001};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'b0000100};
        tbl[11] = '{1'b0, 8'h76, 1'b1, 1'b0, 1'b0, 1'b0, 8'h76, 7'b0010010};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h76, 7'b0001000};
        tbl[13] = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h76, 7'b0001000};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h76, 7'b0000100};
        tbl[15] = '{1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 7'b0010010};
        tbl[16] = '{1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 7'b0000100};
        tbl[17] = '{1'b0, 8'hCB, 1'b1, 1'b0, 1'b0, 1'b0, 8'hCB, 7'b0010010};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCB, 7'b1000100};
        tbl[19] = '{1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 7'b1010010};
        tbl[20] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 7'b0000000};
        tbl[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 7'b0000100};
        tbl[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 7'b0000100};

        reset = 1'b1; fetch_data = 8'h00; fetch_valid = 1'b0;
        instr_done = 1'b0; irq_pending = 1'b0; ime = 1'b0;
        @(negedge clk);

        // directed vector table
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].rst, tbl[i].fd, tbl[i].fv, tbl[i].done, tbl[i].irq, tbl[i].ie);
            check($sformatf("vec%0d_opcode", i), {24'd0, opcode}, {24'd0, tbl[i].e_op});
            check($sformatf("vec%0d_flags", i), {25'd0, dut_flags()}, {25'd0, tbl[i].e_fl});
        end

        // HALT wait: fetch_valid and instr_done are ignored while halted
        step(0, 8'h76, 1, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 8'hAA, 1, k[0], 0, 0);
            check($sformatf("halt_hold%0d", k), {halted, fetch_req, ir_valid, opcode},
                  {1'b1, 1'b0, 1'b0, 8'h76});
        end
        // wake with IME=1 goes straight into interrupt entry
        step(0, 8'h00, 0, 0, 1, 1);
        check("halt_wake_irq", {halted, ir_valid, intr_entry, irq_ack, opcode},
              {1'b0, 1'b1, 1'b1, 1'b1, 8'h00});
        step(0, 8'h00, 0, 1, 1, 1);
        check("intr_end", {fetch_req, intr_entry, irq_ack}, {1'b1, 1'b0, 1'b0});

        // HALT with IME=1 and interrupt already pending
        step(0, 8'h76, 1, 0, 1, 1);
        step(0, 8'h00, 0, 1, 1, 1);
        check("halt_ime_pending", {halted, ir_valid, intr_entry, irq_ack},
              {1'b0, 1'b1, 1'b1, 1'b1});
        step(0, 8'h00, 0, 1, 0, 0);

        // HALT with IME=0 and interrupt pending (halt bug when enabled)
        step(0, 8'h76, 1, 0, 1, 0);
        step(0, 8'h00, 0, 1, 1, 0);
        check("hb_no_halt", {halted, fetch_req}, {1'b0, 1'b1});
        step(0, 8'h04, 1, 0, 0, 0);
        check("hb_fetch1_pcinc", {31'd0, pc_inc}, {31'd0, !HB_EN});
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h05, 1, 0, 0, 0);
        check("hb_fetch2_pcinc", {31'd0, pc_inc}, 32'd1);
        step(0, 8'h00, 0, 1, 0, 0);

        // reset while executing a CB-bank opcode
        step(0, 8'hCB, 1, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0, 0);
        step(0, 8'h11, 1, 0, 0, 0);
        check("pre_reset_cb", {bank_cb, ir_valid}, {1'b1, 1'b1});
        step(1, 8'h00, 0, 0, 0, 0);
        check("reset_exec", {bank_cb, ir_valid, fetch_req, opcode}, {1'b0, 1'b0, 1'b0, 8'h00});
        step(1, 8'h00, 1, 1, 1, 1);
        check("reset_held", {fetch_req, ir_valid, irq_ack, pc_inc}, 4'b0000);
        step(0, 8'h00, 0, 0, 0, 0);

        // randomized stimulus against the behavioural model
        for (int c = 0; c < 3000; c++) begin
            logic       r, fv, dn, iq, ie_r;
            logic [7:0] d;
            int         sel;
            r    = ($urandom_range(0, 63) == 0);
            fv   = $urandom_range(0, 1);
            dn   = ($urandom_range(0, 2) == 0);
            iq   = ($urandom_range(0, 3) == 0);
            ie_r = $urandom_range(0, 1);
            sel  = $urandom_range(0, 3);
            d    = (sel == 0) ? 8'hCB : (sel == 1) ? 8'h76 : 8'($urandom_range(0, 255));
            step(r, d, fv, dn, iq, ie_r);
            check($sformatf("rand%0d", c), {17'd0, opcode, dut_flags()},
                  {17'd0, m_op, model_flags()});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sm83_ir_seq.md
Name: sm83_ir_seq

Overview:
Instruction-register sequencer for the SM83 core. It produces the `opcode`, `bank_cb` and `intr_entry` signals that the instruction decoder consumes, and it owns opcode fetch handshaking. It also covers CB-prefix banking, interrupt-entry injection and HALT wait. It sits between the memory/bus interface and the decoder/execute sequencer.

Parameters:
RESET_OPCODE, 8'h00, value of `opcode` after reset and during interrupt entry.
HALT_OPCODE, 8'h76, bank-0 opcode that enters HALT.
PREFIX_OPCODE, 8'hCB, bank-0 opcode that selects the CB bank.

Ports:
clk  in  1  core clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
fetch_data  in  8  opcode byte from the bus.
fetch_valid  in  1  `fetch_data` valid this cycle.
fetch_req  out  1  sequencer is waiting for an opcode byte.
pc_inc  out  1  one-cycle pulse: PC must increment for the accepted fetch.
instr_done  in  1  execute stage reports the final M-cycle of the current instruction.
irq_pending  in  1  an enabled interrupt is requested (IE & IF != 0).
ime  in  1  effective interrupt master enable.
irq_ack  out  1  one-cycle pulse when interrupt entry begins.
opcode  out  8  instruction register, to the decoder.
bank_cb  out  1  current opcode is from the CB bank.
intr_entry  out  1  current "instruction" is interrupt dispatch.
ir_valid  out  1  `opcode`, `bank_cb` and `intr_entry` are valid for execute.
halted  out  1  core is in HALT.

Behaviour:
- States: FETCH, EXEC, HALTED. Reset state is FETCH.
- Reset values (applied at the edge where `reset`=1):
  - `opcode`=RESET_OPCODE.
  - `bank_cb`, `intr_entry`, `ir_valid`, `irq_ack`, `pc_inc`, `halted` = 0.
  - halt-bug flag = 0.
  - `fetch_req` = (state==FETCH) && !reset, so it is 0 while reset is held.
- Reset mid-instruction discards the current instruction, including a pending CB prefix or interrupt entry.
- FETCH:
  - `fetch_req`=1, `ir_valid`=0.
  - On an edge with `fetch_valid`=1: `opcode`<=`fetch_data`; go to EXEC.
  - `pc_inc` pulses for 1 cycle, registered with the accept, unless the halt-bug flag is set. In that case `pc_inc` stays 0 and the flag clears.
  - `bank_cb` is retained, so a fetch after the prefix lands in the CB bank.
  - Latency: fetch accept edge -> `ir_valid`=1 in the next cycle.
- EXEC:
  - `ir_valid`=1. `fetch_valid` is ignored.
  - On `instr_done`, one transition, evaluated in this priority order:
    1. `!bank_cb && !intr_entry && opcode==PREFIX_OPCODE`: `bank_cb`<=1, go to FETCH. Interrupts are never taken between the prefix and its CB opcode.
    2. `irq_pending && ime && !intr_entry`: stay in EXEC with `intr_entry`<=1, `opcode`<=RESET_OPCODE, `bank_cb`<=0, `irq_ack` pulses 1 cycle. `ir_valid` remains 1.
    3. `!bank_cb && !intr_entry && opcode==HALT_OPCODE`: go to HALTED, `bank_cb`<=0.
    4. Otherwise: `bank_cb`<=0, `intr_entry`<=0, go to FETCH.
  - Rule 2 applies after a HALT opcode too: HALT with IME=1 and an interrupt already pending enters interrupt entry directly.
  - The `instr_done` that ends an interrupt entry always goes to FETCH with `intr_entry`<=0.
- HALTED:
  - `halted`=1, `ir_valid`=0, `fetch_req`=0.
  - When `irq_pending`=1 and `ime`=1: go to EXEC with interrupt entry (as rule 2), `halted`<=0.
  - When `irq_pending`=1 and `ime`=0: go to FETCH, `halted`<=0.
  - `irq_pending`=0: remain in HALTED.
- Halt bug: when rule 3 is evaluated and `irq_pending`=1 with `ime`=0, the sequencer goes to FETCH, not HALTED, and sets the halt-bug flag. The next fetch then does not increment PC.
- Ignored inputs: `instr_done` while `ir_valid`=0; `fetch_valid` outside FETCH.
- Simultaneous `reset` and any other input: reset wins.

Optional Feature:
SM83_HALT_BUG_EN.
- Defined: the halt-bug flag and the suppressed `pc_inc` are implemented as described above.
- Undefined: the flag is absent and `pc_inc` pulses on every accepted fetch. HALT with IME=0 and an interrupt pending goes to FETCH without suppressing PC increment.

Test Plan:
- Reset for 2 cycles, release -> `fetch_req`=1 and `opcode`=8'h00; `fetch_data`=8'h3C with `fetch_valid` -> next cycle `opcode`=8'h3C, `ir_valid`=1, `pc_inc` pulse, `bank_cb`=0.
- Fetch 8'hCB, `instr_done` with `irq_pending`=1 and `ime`=1 -> no `irq_ack`, `fetch_req`=1 with `bank_cb`=1. Fetch 8'h37, `instr_done` -> `intr_entry`=1, `opcode`=8'h00, `irq_ack` pulse. Next `instr_done` -> FETCH with `intr_entry`=0.
- Fetch 8'h76 with `irq_pending`=0, `instr_done` -> `halted`=1, `fetch_req`=0 for 10 cycles. Raise `irq_pending` with `ime`=0 -> FETCH, next fetch produces a `pc_inc` pulse.
- With SM83_HALT_BUG_EN, fetch 8'h76 with `irq_pending`=1 and `ime`=0, `instr_done` -> `halted` stays 0; next fetch gives `pc_inc`=0, the fetch after that gives `pc_inc`=1. Without the macro, both fetches give `pc_inc`=1.
- Assert `reset` in EXEC with `bank_cb`=1 -> next cycle `bank_cb`=0, `ir_valid`=0, `opcode`=8'h00, `fetch_req`=0 while reset is held.
- Hold `fetch_valid`=1 during EXEC and HALTED, and pulse `instr_done` in FETCH -> no change to `opcode` or state.
